// File: rtl/unary_pkg.sv
// Shared types and constants for the unary adder driver slice.
package unary_pkg;

  localparam int UNARY_W = 6;

  // read_or_write encodings seen by the unary adder
  localparam logic PH_READ  = 1'b0;
  localparam logic PH_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/unary_stream_ser.sv
// Binary-to-unary serializer: after a start pulse the registered stream is
// high for exactly `value` consecutive cycles, then low until the next start.
module unary_stream_ser #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] value,
  output logic         stream
);

  logic [W-1:0] rem;

  // Down-counter of ones still to emit after the current cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem    <= '0;
      stream <= 1'b0;
    end else if (start) begin
      stream <= (value != '0);
      rem    <= (value != '0) ? value - W'(1) : '0;
    end else if (rem != '0) begin
      stream <= 1'b1;
      rem    <= rem - W'(1);
    end else begin
      stream <= 1'b0;
    end
  end

endmodule

// File: rtl/unary_add_driver.sv
// Unary adder initiator: serializes two binary operands into aligned unary
// streams, switches the adder to its emit phase, counts the returned ones and
// hands back the binary sum with an overflow flag.
//
//   state | meaning
//   IDLE  | waiting for an operand pair, adder disabled
//   READ  | streaming max(a,b) cycles of A/B into the adder
//   WRITE | w0 lets the adder see the phase change, w1.. count dout ones
//   DONE  | result held on res_* until res_ready
module unary_add_driver
  import unary_pkg::*;
#(
  parameter int W = UNARY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         en,
  output logic         A,
  output logic         B,
  output logic         read_or_write,
  input  logic         dout,
  input  logic         C,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_sum,
  output logic         res_ovf
);

  state_t       state;
  logic [W-1:0] rd_rem;
  logic [W-1:0] ones;
  logic         ovf;
  logic         first_w;
  logic         accept;
  logic [W-1:0] len;

  assign op_ready = (state == IDLE);
  assign accept   = op_valid && op_ready;
  assign len      = (op_a > op_b) ? op_a : op_b;

  // Both serializers load on the accept edge so their ones start together.
  unary_stream_ser #(.W(W)) u_ser_a (
    .clk    (clk),
    .rst    (rst),
    .start  (accept),
    .value  (op_a),
    .stream (A)
  );

  unary_stream_ser #(.W(W)) u_ser_b (
    .clk    (clk),
    .rst    (rst),
    .start  (accept),
    .value  (op_b),
    .stream (B)
  );

  // Control FSM with registered adder controls, ones counter and ovf sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      en            <= 1'b0;
      read_or_write <= PH_READ;
      res_valid     <= 1'b0;
      res_sum       <= '0;
      res_ovf       <= 1'b0;
      rd_rem        <= '0;
      ones          <= '0;
      ovf           <= 1'b0;
      first_w       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ones <= '0;
            ovf  <= 1'b0;
            en   <= 1'b1;
            if (len != '0) begin
              state         <= READ;
              rd_rem        <= len - W'(1);
              read_or_write <= PH_READ;
            end else begin
              state         <= WRITE;
              read_or_write <= PH_WRITE;
              first_w       <= 1'b1;
            end
          end
        end
        READ: begin
          ovf <= ovf | C;
          if (rd_rem == '0) begin
            state         <= WRITE;
            read_or_write <= PH_WRITE;
            first_w       <= 1'b1;
          end else begin
            rd_rem <= rd_rem - W'(1);
          end
        end
        WRITE: begin
          if (first_w) begin
            // C still carries the flag from the last read edge here.
            ovf     <= ovf | C;
            first_w <= 1'b0;
          end else if (dout) begin
            ones <= ones + W'(1);
          end else begin
            state         <= DONE;
            en            <= 1'b0;
            read_or_write <= PH_READ;
            res_valid     <= 1'b1;
            res_sum       <= ones;
            res_ovf       <= ovf;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unary_add_driver.sv
// Directed bench for unary_add_driver with a behavioural unary adder model.
module tb_unary_add_driver;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         op_valid = 1'b0;
  logic         op_ready;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         en;
  logic         A;
  logic         B;
  logic         read_or_write;
  logic         dout;
  logic         C;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_sum;
  logic         res_ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  unary_add_driver #(.W(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .op_valid      (op_valid),
    .op_ready      (op_ready),
    .op_a          (op_a),
    .op_b          (op_b),
    .en            (en),
    .A             (A),
    .B             (B),
    .read_or_write (read_or_write),
    .dout          (dout),
    .C             (C),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_sum       (res_sum),
    .res_ovf       (res_ovf)
  );

  // Unary adder model: accumulates A+B in read phase, emits ones in write phase.
  logic [W-1:0] add_cnt;
  always @(posedge clk) begin
    logic [W:0] tmp;
    if (rst) begin
      add_cnt <= '0;
      dout    <= 1'b0;
      C       <= 1'b0;
    end else if (en) begin
      if (!read_or_write) begin
        tmp     = {1'b0, add_cnt} + (W+1)'(A) + (W+1)'(B);
        add_cnt <= tmp[W-1:0];
        C       <= C | tmp[W];
      end else begin
        C <= 1'b0;
        if (add_cnt != '0) begin
          dout    <= 1'b1;
          add_cnt <= add_cnt - 1'b1;
        end else begin
          dout <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // The adder must be disabled whenever the driver is idle or holding a result.
  always @(negedge clk) begin
    if (!rst && (op_ready === 1'b1 || res_valid === 1'b1))
      chk("en_idle", int'(en), 0);
  end

  // Offer an operand pair; returns at the negedge after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    logic acc;
    int   n;
    logic ok;
    op_valid = 1'b1;
    op_a = a;
    op_b = b;
    ok = 1'b0;
    n = 0;
    while (!ok && n < 100) begin
      acc = op_ready;
      @(negedge clk);
      if (acc) ok = 1'b1;
      n++;
    end
    op_valid = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  // Watch READ/WRITE cycles until res_valid, recording the A/B streams.
  task automatic collect(output int rdc, output int wrc,
                         output logic [63:0] abits, output logic [63:0] bbits);
    int n;
    rdc = 0;
    wrc = 0;
    abits = '0;
    bbits = '0;
    n = 0;
    while (res_valid !== 1'b1 && n < 400) begin
      if (en && !read_or_write) begin
        if (rdc < 64) begin
          abits[rdc] = A;
          bbits[rdc] = B;
        end
        rdc++;
      end else if (en && read_or_write) begin
        wrc++;
      end
      @(negedge clk);
      n++;
    end
    if (res_valid !== 1'b1) chk("result_timeout", 0, 1);
  endtask

  task automatic release_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_valid_clear", int'(res_valid), 0);
  endtask

  task automatic run_txn(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int exp_sum, input int exp_ovf, input int exp_rd, input int exp_wr);
    int rdc, wrc;
    logic [63:0] ab, bb;
    send(a, b);
    collect(rdc, wrc, ab, bb);
    chk({tag, "_sum"}, int'(res_sum), exp_sum);
    chk({tag, "_ovf"}, int'(res_ovf), exp_ovf);
    chk({tag, "_read_cycles"}, rdc, exp_rd);
    chk({tag, "_write_cycles"}, wrc, exp_wr);
    release_result();
  endtask

  initial begin
    int rdc, wrc, wc, n;
    logic [63:0] ab, bb;
    int ra, rb, rs, ro, rm;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_op_ready", int'(op_ready), 1);
    chk("rst_en", int'(en), 0);
    chk("rst_ab", int'({A, B}), 0);
    chk("rst_rw", int'(read_or_write), 0);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_sum", int'(res_sum), 0);
    chk("rst_res_ovf", int'(res_ovf), 0);

    // 3 + 4 with stream shape
    send(6'd3, 6'd4);
    collect(rdc, wrc, ab, bb);
    chk("s34_read_cycles", rdc, 4);
    chk("s34_a_stream", int'(ab[3:0]), 4'b0111);
    chk("s34_b_stream", int'(bb[3:0]), 4'b1111);
    chk("s34_write_cycles", wrc, 9);
    chk("s34_sum", int'(res_sum), 7);
    chk("s34_ovf", int'(res_ovf), 0);
    release_result();

    // Boundaries and overflow
    run_txn("zero", 6'd0, 6'd0, 0, 0, 0, 2);
    run_txn("s40_30", 6'd40, 6'd30, 6, 1, 40, 8);
    run_txn("s32_32", 6'd32, 6'd32, 0, 1, 32, 2);
    run_txn("s63_0", 6'd63, 6'd0, 63, 0, 63, 65);
    run_txn("s0_63", 6'd0, 6'd63, 63, 0, 63, 65);

    // Back-to-back with a stalled consumer
    send(6'd5, 6'd9);
    collect(rdc, wrc, ab, bb);
    chk("b2b1_sum", int'(res_sum), 14);
    op_valid = 1'b1;
    op_a = 6'd10;
    op_b = 6'd1;
    for (int k = 0; k < 7; k++) begin
      chk("stall_valid", int'(res_valid), 1);
      chk("stall_sum", int'(res_sum), 14);
      chk("stall_op_ready", int'(op_ready), 0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("b2b_handshake_valid", int'(res_valid), 0);
    chk("b2b_handshake_ready", int'(op_ready), 1);
    send(6'd10, 6'd1);
    collect(rdc, wrc, ab, bb);
    chk("b2b2_sum", int'(res_sum), 11);
    chk("b2b2_ovf", int'(res_ovf), 0);
    release_result();

    // Reset in WRITE cycle w3 of 20 + 20
    send(6'd20, 6'd20);
    wc = 0;
    n = 0;
    while (n < 200 && !(en === 1'b1 && read_or_write === 1'b1 && wc == 3)) begin
      if (en && read_or_write) wc++;
      @(negedge clk);
      n++;
    end
    chk("w3_reached", wc, 3);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_en", int'(en), 0);
    chk("mid_rst_rw", int'(read_or_write), 0);
    chk("mid_rst_ab", int'({A, B}), 0);
    chk("mid_rst_valid", int'(res_valid), 0);
    chk("mid_rst_sum", int'(res_sum), 0);
    chk("mid_rst_op_ready", int'(op_ready), 1);
    rst = 1'b0;
    @(negedge clk);
    run_txn("after_rst", 6'd2, 6'd2, 4, 0, 2, 6);

    // Random operand pairs against a reference model
    for (int k = 0; k < 200; k++) begin
      ra = $urandom_range(0, 63);
      rb = $urandom_range(0, 63);
      rs = (ra + rb) % 64;
      ro = (ra + rb >= 64) ? 1 : 0;
      rm = (ra > rb) ? ra : rb;
      run_txn("rand", ra[W-1:0], rb[W-1:0], rs, ro, rm, rs + 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
